rca_wb_sequencer: RTL and testbench
===================================

Name: rca_wb_sequencer

Overview:
- Consumer end of the RCA writeback path: accepts a multi-result completion (id plus NUM_WRITE_PORTS rd values) from the RCA unit.
- Buffers each completion together with a snapshot of its destination-register config.
- Drains results to the single CPU register-file write port, one register per granted cycle.
- Emits one commit pulse per instruction once all of its registers are written.

Parameters:
- NUM_WRITE_PORTS, 5, result lanes per RCA instruction (from the shared RCA package).
- XLEN, 32, data width (riscv_types).
- DEPTH, 2, completion buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- done_in  in  1  RCA completion strobe, one cycle per instruction
- id_in  in  id_t  instruction id of the completion
- rd_in  in  XLEN x NUM_WRITE_PORTS  result values
- dest_addrs_in  in  5 x NUM_WRITE_PORTS  destination register per lane
- port_en_in  in  NUM_WRITE_PORTS  lane-used mask
- rca_ready  out  1  buffer can take a completion; gates issue.ready upstream
- rf_wr_en  out  1  register-file write request
- rf_wr_addr  out  5  write address
- rf_wr_data  out  XLEN  write data
- rf_wr_id  out  id_t  owning instruction id
- rf_wr_gnt  in  1  register file accepted this cycle's write
- commit_valid  out  1  one-cycle pulse; instruction fully written back
- commit_id  out  id_t  id being committed
- overflow  out  1  sticky; completion arrived while full

Behaviour:
- Reset (synchronous, rst high at edge):
  - buffer empty, state IDLE, pending mask 0, overflow 0.
  - rf_wr_en, commit_valid and all data/id/address outputs are 0; rca_ready=1 on the first cycle after reset.
  - Reset mid-operation abandons all buffered and in-flight entries with no commit and no further writes.
- Capture:
  - On done_in with count<DEPTH, push the entry {id_in, rd_in, dest_addrs_in, wmask}.
  - wmask[i] = port_en_in[i] && dest_addrs_in[i]!=0; writes to x0 are suppressed.
  - The config snapshot is taken at capture, so later config writes do not affect buffered entries.
- Ready and overflow:
  - rca_ready = (count<DEPTH), combinational from registered count.
  - done_in while full: entry dropped, overflow set until reset.
  - A push and a pop in the same cycle are both honoured; count unchanged.
- FSM states IDLE, WRITE, COMMIT:
  - IDLE: if buffer non-empty, load pending <= head.wmask, go to WRITE.
  - WRITE:
    - If pending!=0: rf_wr_en=1, selecting the lowest set bit k; drive rf_wr_addr=head.dest[k], rf_wr_data=head.rd[k], rf_wr_id=head.id.
    - On rf_wr_gnt, clear bit k. If that was the last bit, go to COMMIT. Without a grant, hold all outputs stable.
    - If pending==0 on entry (no enabled lanes), go to COMMIT with no write.
  - COMMIT: commit_valid=1, commit_id=head.id, pop head, go to IDLE.
- Outputs outside WRITE: rf_wr_en=0; rf_wr_addr, rf_wr_data and rf_wr_id are driven 0.
- Latency, with gnt tied high and k used lanes:
  - done_in in cycle 0; IDLE in cycle 1; writes in cycles 2..k+1; commit_valid in cycle k+2.
  - k=0: commit in cycle 3.
- Ordering:
  - Commits occur in strict arrival order.
  - Writes within an instruction go in ascending lane index.
  - No write of entry n+1 may occur before commit of entry n.
- Duplicate dest addresses across lanes: both lanes are written in lane order, so the higher lane's value wins.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Decomposition:
- Shared RCA package:
  - rca_wb_entry_t struct {id_t id; logic [XLEN-1:0] rd[NUM_WRITE_PORTS]; logic [4:0] dest[NUM_WRITE_PORTS]; logic [NUM_WRITE_PORTS-1:0] wmask;}
  - rca_wb_state_t enum {IDLE, WRITE, COMMIT}.
- NUM_WRITE_PORTS stays in the existing RCA constants.
- One sub-module: rca_wb_entry_fifo.
  - Register-based FIFO of rca_wb_entry_t with push, pop, head, count, full and empty.
  - Top level holds the FSM, the lowest-set-bit priority select and output muxing.

Test Plan:
- Reset then one completion: id=3, lanes 0..4 enabled, dest 5,6,7,8,9, rd 0xA..0xE, gnt=1 -> writes (5,0xA)…(9,0xE) in cycles 2–6, commit_valid with id 3 in cycle 7.
- port_en=5'b10101 with dest[2]=0, gnt=1 -> exactly two writes, to lanes 0 then 4; commit two cycles after the lane-0 write.
- Backpressure: gnt held 0 for 3 cycles during the first write -> rf_wr_en/addr/data stable all 3 cycles, single write on grant, commit delayed by 3 cycles.
- Three back-to-back done_in with DEPTH=2, gnt=0 -> rca_ready falls after the second, third dropped, overflow=1; releasing gnt commits only the first two ids, in order.
- Zero-lane completion (port_en=0) followed immediately by a full one -> first commits in cycle 3 with no writes; second's writes start only after that commit.
- rst asserted during the second write of a 5-lane entry -> next cycle rf_wr_en=0, commit_valid never pulses, rca_ready=1, overflow=0.

Source files
------------

// File: rtl/rca_wb_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rca_wb_sequencer_pkg
// Shared RCA writeback types and constants.
//   NUM_WRITE_PORTS : result lanes per RCA instruction
//   XLEN            : register data width
//   id_t            : instruction id carried with every completion
//   rca_wb_entry_t  : one buffered completion (id, lane results, lane
//                     destinations, and the lanes that really write)
//   rca_wb_state_t  : writeback sequencer states
//   lowest_set()    : index of the lowest set bit of a lane mask
// ---------------------------------------------------------------------------
package rca_wb_sequencer_pkg;

    localparam int NUM_WRITE_PORTS = 5;
    localparam int XLEN            = 32;
    localparam int ID_WIDTH        = 4;
    localparam int LANE_IDX_W      = $clog2(NUM_WRITE_PORTS);

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        id_t                                  id;
        logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd;
        logic [NUM_WRITE_PORTS-1:0][4:0]      dest;
        logic [NUM_WRITE_PORTS-1:0]           wmask;
    } rca_wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } rca_wb_state_t;

    // Scan from the top down so the last hit is the lowest set bit.
    function automatic logic [LANE_IDX_W-1:0] lowest_set(
        input logic [NUM_WRITE_PORTS-1:0] mask
    );
        logic [LANE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = LANE_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rca_wb_entry_fifo.sv
// ---------------------------------------------------------------------------
// rca_wb_entry_fifo
// Register-based FIFO of rca_wb_entry_t completions.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write entry_i (ignored when full)
//   entry_i   : entry to store
//   pop_i     : drop the head entry (ignored when empty)
//   head_o    : oldest entry, valid while empty_o is low
//   count_o   : number of stored entries (0..DEPTH)
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
// A push and a pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module rca_wb_entry_fifo
    import rca_wb_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  rca_wb_entry_t               entry_i,
    input  logic                        pop_i,
    output rca_wb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rca_wb_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed through count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/rca_wb_sequencer.sv
// ---------------------------------------------------------------------------
// rca_wb_sequencer
// Consumer end of the RCA writeback path. Buffers multi-lane completions
// with a snapshot of their destinations and drains them, one register per
// granted cycle, into the single register-file write port; one commit pulse
// per instruction once all its lanes are written.
//   clk, rst        : clock, synchronous active-high reset
//   done_in         : completion strobe (one cycle per instruction)
//   id_in           : instruction id of the completion
//   rd_in           : per-lane result values
//   dest_addrs_in   : per-lane destination register
//   port_en_in      : per-lane used mask
//   rca_ready       : buffer can accept a completion
//   rf_wr_en/addr/data/id : register-file write request
//   rf_wr_gnt       : register file accepted this cycle's write
//   commit_valid/id : one-cycle commit pulse and its id
//   overflow        : sticky, a completion arrived while the buffer was full
// ---------------------------------------------------------------------------
module rca_wb_sequencer
    import rca_wb_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 done_in,
    input  id_t                                  id_in,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_in,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]      dest_addrs_in,
    input  logic [NUM_WRITE_PORTS-1:0]           port_en_in,
    output logic                                 rca_ready,
    output logic                                 rf_wr_en,
    output logic [4:0]                           rf_wr_addr,
    output logic [XLEN-1:0]                      rf_wr_data,
    output id_t                                  rf_wr_id,
    input  logic                                 rf_wr_gnt,
    output logic                                 commit_valid,
    output id_t                                  commit_id,
    output logic                                 overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    rca_wb_state_t              state_q;
    logic [NUM_WRITE_PORTS-1:0] pending_q;
    logic [NUM_WRITE_PORTS-1:0] pending_d;
    logic                       overflow_q;

    rca_wb_entry_t              entry_in;
    rca_wb_entry_t              head;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       pop;

    logic [NUM_WRITE_PORTS-1:0] wmask_in;
    logic [NUM_WRITE_PORTS-1:0] sel_onehot;
    logic [LANE_IDX_W-1:0]      sel_idx;

    // Lanes aimed at x0 are dropped at capture so they never reach the port.
    for (genvar gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_wmask
        assign wmask_in[gi] = port_en_in[gi] && (dest_addrs_in[gi] != 5'd0);
    end

    always_comb begin
        entry_in       = '0;
        entry_in.id    = id_in;
        entry_in.rd    = rd_in;
        entry_in.dest  = dest_addrs_in;
        entry_in.wmask = wmask_in;
    end

    assign pop = (state_q == COMMIT);

    rca_wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (done_in),
        .entry_i (entry_in),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rca_ready = (count < CNT_W'(DEPTH));
    assign overflow  = overflow_q;

    // Lowest pending lane: two's-complement isolation for clearing, index
    // for the data mux.
    assign sel_onehot = pending_q & (~pending_q + NUM_WRITE_PORTS'(1));
    assign sel_idx    = lowest_set(pending_q);
    assign pending_d  = pending_q & ~sel_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (done_in && full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pending_q <= head.wmask;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    if (pending_q == '0) begin
                        state_q <= COMMIT;
                    end else if (rf_wr_gnt) begin
                        pending_q <= pending_d;
                        if (pending_d == '0) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, so they hold steady while
    // the register file withholds its grant.
    always_comb begin
        rf_wr_en     = (state_q == WRITE) && (pending_q != '0);
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        rf_wr_id     = '0;
        commit_valid = (state_q == COMMIT);
        commit_id    = '0;
        if (rf_wr_en) begin
            rf_wr_addr = head.dest[sel_idx];
            rf_wr_data = head.rd[sel_idx];
            rf_wr_id   = head.id;
        end
        if (commit_valid) begin
            commit_id = head.id;
        end
    end

endmodule

// File: tb/tb_rca_wb_sequencer.sv
module tb_rca_wb_sequencer;
    import rca_wb_sequencer_pkg::*;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 done_in;
    id_t                                  id_in;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_in;
    logic [NUM_WRITE_PORTS-1:0][4:0]      dest_addrs_in;
    logic [NUM_WRITE_PORTS-1:0]           port_en_in;
    logic                                 rca_ready;
    logic                                 rf_wr_en;
    logic [4:0]                           rf_wr_addr;
    logic [XLEN-1:0]                      rf_wr_data;
    id_t                                  rf_wr_id;
    logic                                 rf_wr_gnt;
    logic                                 commit_valid;
    id_t                                  commit_id;
    logic                                 overflow;

    rca_wb_sequencer #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .done_in       (done_in),
        .id_in         (id_in),
        .rd_in         (rd_in),
        .dest_addrs_in (dest_addrs_in),
        .port_en_in    (port_en_in),
        .rca_ready     (rca_ready),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .rf_wr_id      (rf_wr_id),
        .rf_wr_gnt     (rf_wr_gnt),
        .commit_valid  (commit_valid),
        .commit_id     (commit_id),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  id;
    } wr_rec_t;

    typedef struct {
        int         cyc;
        logic [3:0] id;
    } cm_rec_t;

    wr_rec_t wr_q[$];
    cm_rec_t cm_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted write and every commit, one line per transaction.
    always @(negedge clk) begin
        wr_rec_t w;
        cm_rec_t c;
        if (rf_wr_en && rf_wr_gnt) begin
            w.cyc = cyc; w.addr = rf_wr_addr; w.data = rf_wr_data; w.id = rf_wr_id;
            wr_q.push_back(w);
            $display("[%0d] write addr=%0d data=0x%0h id=%0d", cyc, rf_wr_addr, rf_wr_data, rf_wr_id);
        end
        if (commit_valid) begin
            c.cyc = cyc; c.id = commit_id;
            cm_q.push_back(c);
            $display("[%0d] commit id=%0d", cyc, commit_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpl(input logic [3:0] id, input logic [4:0] en,
                             input logic [4:0][4:0] dest, input logic [31:0] base);
        id_in         = id;
        port_en_in    = en;
        dest_addrs_in = dest;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) rd_in[i] = base + 32'(i);
        done_in       = 1'b1;
    endtask

    task automatic start_test();
        wr_q.delete();
        cm_q.delete();
        c0 = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; done_in = 1'b0; id_in = '0; rd_in = '0;
        dest_addrs_in = '0; port_en_in = '0; rf_wr_gnt = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", rf_wr_en); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit_valid); end
        checks++; if (rca_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rca_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if ({rf_wr_addr, rf_wr_data, rf_wr_id, commit_id} !== '0) begin
            errors++; $display("FAIL reset_outputs addr=%0d data=0x%0h id=%0d cid=%0d exp=all 0",
                               rf_wr_addr, rf_wr_data, rf_wr_id, commit_id);
        end
        repeat (2) tick();
    endtask

    task automatic test_full_lanes();
        rf_wr_gnt = 1'b1;
        start_test();
        drive_cpl(4'd3, 5'b11111, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 32'hA);
        tick();
        done_in = 1'b0;
        checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL full_cycle1_wr_en got=%b exp=0", rf_wr_en); end
        repeat (10) tick();
        checks++;
        if (wr_q.size() != 5) begin
            errors++; $display("FAIL full_write_count got=%0d exp=5", wr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_q[i].cyc != c0 + 2 + i || wr_q[i].addr !== 5'(5 + i) ||
                    wr_q[i].data !== 32'(10 + i) || wr_q[i].id !== 4'd3) begin
                    errors++;
                    $display("FAIL full_write%0d got cyc=%0d addr=%0d data=0x%0h id=%0d exp cyc=%0d addr=%0d data=0x%0h id=3",
                             i, wr_q[i].cyc - c0, wr_q[i].addr, wr_q[i].data, wr_q[i].id, 2 + i, 5 + i, 10 + i);
                end
            end
        end
        checks++;
        if (cm_q.size() != 1 || cm_q[0].cyc != c0 + 7 || cm_q[0].id !== 4'd3) begin
            errors++; $display("FAIL full_commit got n=%0d cyc=%0d id=%0d exp n=1 cyc=7 id=3",
                               cm_q.size(), cm_q.size() > 0 ? cm_q[0].cyc - c0 : -1,
                               cm_q.size() > 0 ? cm_q[0].id : 4'd0);
        end
    endtask

    task automatic test_sparse_x0();
        rf_wr_gnt = 1'b1;
        start_test();
        drive_cpl(4'd7, 5'b10101, {5'd9, 5'd8, 5'd0, 5'd6, 5'd5}, 32'h100);
        tick();
        done_in = 1'b0;
        repeat (8) tick();
        checks++;
        if (wr_q.size() != 2) begin
            errors++; $display("FAIL sparse_write_count got=%0d exp=2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].cyc != c0 + 2 || wr_q[0].addr !== 5'd5 || wr_q[0].data !== 32'h100) begin
                errors++; $display("FAIL sparse_lane0 got cyc=%0d addr=%0d data=0x%0h exp cyc=2 addr=5 data=0x100",
                                   wr_q[0].cyc - c0, wr_q[0].addr, wr_q[0].data);
            end
            checks++;
            if (wr_q[1].cyc != c0 + 3 || wr_q[1].addr !== 5'd9 || wr_q[1].data !== 32'h104) begin
                errors++; $display("FAIL sparse_lane4 got cyc=%0d addr=%0d data=0x%0h exp cyc=3 addr=9 data=0x104",
                                   wr_q[1].cyc - c0, wr_q[1].addr, wr_q[1].data);
            end
        end
        checks++;
        if (cm_q.size() != 1 || cm_q[0].cyc != c0 + 4 || cm_q[0].id !== 4'd7) begin
            errors++; $display("FAIL sparse_commit got n=%0d exp n=1 cyc=4 id=7", cm_q.size());
        end
    endtask

    task automatic test_backpressure();
        rf_wr_gnt = 1'b0;
        start_test();
        drive_cpl(4'd2, 5'b11111, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 32'h20);
        tick();
        done_in = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h20 || rf_wr_id !== 4'd2) begin
                errors++; $display("FAIL stall_hold cycle=%0d got en=%b addr=%0d data=0x%0h id=%0d exp en=1 addr=5 data=0x20 id=2",
                                   c, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_id);
            end
        end
        tick();
        rf_wr_gnt = 1'b1;
        repeat (8) tick();
        checks++;
        if (wr_q.size() != 5) begin
            errors++; $display("FAIL stall_write_count got=%0d exp=5", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].cyc != c0 + 5 || wr_q[0].addr !== 5'd5 || wr_q[4].cyc != c0 + 9 || wr_q[4].addr !== 5'd9) begin
                errors++; $display("FAIL stall_write_cycles got first=%0d last=%0d exp first=5 last=9",
                                   wr_q[0].cyc - c0, wr_q[4].cyc - c0);
            end
        end
        checks++;
        if (cm_q.size() != 1 || cm_q[0].cyc != c0 + 10 || cm_q[0].id !== 4'd2) begin
            errors++; $display("FAIL stall_commit got n=%0d exp n=1 cyc=10 id=2", cm_q.size());
        end
    endtask

    task automatic test_zero_then_full();
        rf_wr_gnt = 1'b1;
        start_test();
        drive_cpl(4'd4, 5'b00000, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, 32'h40);
        tick();
        drive_cpl(4'd5, 5'b11111, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 32'h50);
        tick();
        done_in = 1'b0;
        repeat (12) tick();
        checks++;
        if (cm_q.size() != 2) begin
            errors++; $display("FAIL zero_commit_count got=%0d exp=2", cm_q.size());
        end else begin
            checks++;
            if (cm_q[0].cyc != c0 + 3 || cm_q[0].id !== 4'd4) begin
                errors++; $display("FAIL zero_commit got cyc=%0d id=%0d exp cyc=3 id=4", cm_q[0].cyc - c0, cm_q[0].id);
            end
            checks++;
            if (cm_q[1].cyc != c0 + 10 || cm_q[1].id !== 4'd5) begin
                errors++; $display("FAIL zero_next_commit got cyc=%0d id=%0d exp cyc=10 id=5", cm_q[1].cyc - c0, cm_q[1].id);
            end
        end
        checks++;
        if (wr_q.size() != 5 || wr_q[0].cyc != c0 + 5 || wr_q[0].id !== 4'd5 || wr_q[0].data !== 32'h50) begin
            errors++; $display("FAIL zero_next_writes got n=%0d first_cyc=%0d exp n=5 first_cyc=5",
                               wr_q.size(), wr_q.size() > 0 ? wr_q[0].cyc - c0 : -1);
        end
    endtask

    task automatic test_back_to_back();
        rf_wr_gnt = 1'b0;
        start_test();
        drive_cpl(4'd1, 5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd10}, 32'h111);
        tick();
        checks++; if (rca_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c1 got=%b exp=1", rca_ready); end
        drive_cpl(4'd2, 5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd11}, 32'h222);
        tick();
        checks++; if (rca_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b exp=0", rca_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow_early got=%b exp=0", overflow); end
        drive_cpl(4'd3, 5'b00001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd12}, 32'h333);
        tick();
        done_in = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow got=%b exp=1", overflow); end
        tick();
        rf_wr_gnt = 1'b1;
        repeat (12) tick();
        checks++;
        if (cm_q.size() != 2) begin
            errors++; $display("FAIL b2b_commit_count got=%0d exp=2", cm_q.size());
        end else begin
            checks++;
            if (cm_q[0].id !== 4'd1 || cm_q[0].cyc != c0 + 5 || cm_q[1].id !== 4'd2 || cm_q[1].cyc != c0 + 8) begin
                errors++; $display("FAIL b2b_commit_order got id=%0d@%0d id=%0d@%0d exp id=1@5 id=2@8",
                                   cm_q[0].id, cm_q[0].cyc - c0, cm_q[1].id, cm_q[1].cyc - c0);
            end
        end
        checks++;
        if (wr_q.size() != 2) begin
            errors++; $display("FAIL b2b_write_count got=%0d exp=2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].addr !== 5'd10 || wr_q[0].data !== 32'h111 || wr_q[0].cyc != c0 + 4 ||
                wr_q[1].addr !== 5'd11 || wr_q[1].data !== 32'h222 || wr_q[1].cyc != c0 + 7) begin
                errors++; $display("FAIL b2b_writes got %0d@%0d %0d@%0d exp 10@4 11@7",
                                   wr_q[0].addr, wr_q[0].cyc - c0, wr_q[1].addr, wr_q[1].cyc - c0);
            end
        end
        checks++;
        if (overflow !== 1'b1 || rca_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_after got overflow=%b ready=%b exp overflow=1 ready=1", overflow, rca_ready);
        end
    endtask

    task automatic test_reset_mid();
        rf_wr_gnt = 1'b1;
        start_test();
        drive_cpl(4'd6, 5'b11111, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5}, 32'h60);
        tick();
        done_in = 1'b0;
        repeat (2) tick();
        checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd6) begin
            errors++; $display("FAIL rstmid_second_write got en=%b addr=%0d exp en=1 addr=6", rf_wr_en, rf_wr_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rf_wr_en !== 1'b0 || commit_valid !== 1'b0 || rca_ready !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got en=%b commit=%b ready=%b overflow=%b exp 0 0 1 0",
                               rf_wr_en, commit_valid, rca_ready, overflow);
        end
        repeat (10) tick();
        checks++;
        if (cm_q.size() != 0 || wr_q.size() != 2) begin
            errors++; $display("FAIL rstmid_abandon got commits=%0d writes=%0d exp commits=0 writes=2",
                               cm_q.size(), wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_lanes();
        test_sparse_x0();
        test_backpressure();
        test_zero_then_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
